cp0_regs: RTL and testbench

CP0_REGS -- requirements
Module: cp0_regs

---
 rtl/cp0_regs_pkg.sv | 33 +++
 rtl/cp0_regs_if.sv | 29 ++
 rtl/cp0_timer.sv | 46 ++++
 rtl/cp0_regs.sv | 112 +++++++++++
 tb/tb_cp0_regs.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/cp0_regs_pkg.sv
// Shared CP0 definitions: register indices, exception codes and register packing helpers.
package cp0_regs_pkg;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   typedef enum logic [4:0] {
      EXC_INT  = 5'h00,
      EXC_ADEL = 5'h04,
      EXC_ADES = 5'h05,
      EXC_SYS  = 5'h08,
      EXC_BP   = 5'h09,
      EXC_RI   = 5'h0a,
      EXC_OV   = 5'h0c
   } exc_code_e;

   // BEV (bit 22) is hard-wired to 1; only IM, EXL and IE are state.
   function automatic logic [31:0] pack_status(input logic [7:0] im, input logic exl,
                                               input logic ie);
      return {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
   endfunction

   function automatic logic [31:0] pack_cause(input logic bd, input logic ti,
                                              input logic [5:0] ip_hw, input logic [1:0] ip_sw,
                                              input logic [4:0] exccode);
      return {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exccode, 2'b0};
   endfunction

endpackage

// File: rtl/cp0_regs_if.sv
// Pipeline-to-CP0 signal bundle: MFC0/MTC0 access, exception/ERET commit and interrupt status.
interface cp0_regs_if;
   logic [4:0]  cp0_idx;
   logic        cp0_write;
   logic [31:0] cp0_data2w;
   logic [31:0] cp0_val;
   logic [5:0]  exc_code;
   logic [31:0] exc_pc;
   logic        exc_in_delay_slot;
   logic [31:0] exc_badvaddr;
   logic        eret;
   logic [5:0]  ext_int;
   logic [31:0] d_epc;
   logic [31:0] exc_target;
   logic        int_req;
   logic        status_exl;

   modport master (
      output cp0_idx, cp0_write, cp0_data2w, exc_code, exc_pc, exc_in_delay_slot,
             exc_badvaddr, eret, ext_int,
      input  cp0_val, d_epc, exc_target, int_req, status_exl
   );

   modport slave (
      input  cp0_idx, cp0_write, cp0_data2w, exc_code, exc_pc, exc_in_delay_slot,
             exc_badvaddr, eret, ext_int,
      output cp0_val, d_epc, exc_target, int_req, status_exl
   );
endinterface

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, TI latches on a non-zero match.
module cp0_timer
   import cp0_regs_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   logic        tick;
   logic [31:0] count_nxt;
   logic [31:0] compare_nxt;

   always_comb begin
      count_nxt   = tick ? count + 32'd1 : count;
      compare_nxt = compare;
      if (count_we)
         count_nxt = wdata;
      if (compare_we)
         compare_nxt = wdata;
   end

   // TI compares against the post-update values so a match is seen on the cycle Count lands on it.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         tick    <= 1'b0;
         count   <= 32'd0;
         compare <= 32'd0;
         ti      <= 1'b0;
      end else begin
         tick    <= count_we ? 1'b0 : ~tick;
         count   <= count_nxt;
         compare <= compare_nxt;
         if (compare_we)
            ti <= 1'b0;
         else if ((count_nxt == compare_nxt) && (count_nxt != 32'd0))
            ti <= 1'b1;
      end
   end

endmodule

// File: rtl/cp0_regs.sv
// MIPS CP0 register file: Status/Cause/EPC/BadVAddr, exception entry, ERET and interrupt request.
module cp0_regs
   import cp0_regs_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
)(
   input  logic        clk,
   input  logic        resetn,
   cp0_regs_if.slave   bus
);

   logic        exc_valid;
   logic        mtc0_en;
   logic        wr_count;
   logic        wr_compare;

   logic [7:0]  status_im;
   logic        status_exl_r;
   logic        status_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip_hw;
   logic [1:0]  cause_ip_sw;
   logic [4:0]  cause_exccode;
   logic [31:0] epc;
   logic [31:0] badvaddr;

   logic [31:0] count;
   logic [31:0] compare;
   logic        ti;
   logic [31:0] status_val;
   logic [31:0] cause_val;

   // Exception beats ERET beats MTC0; a losing MTC0 must not reach the timer either.
   assign exc_valid  = bus.exc_code[5];
   assign mtc0_en    = bus.cp0_write & ~exc_valid & ~bus.eret;
   assign wr_count   = mtc0_en && (bus.cp0_idx == CP0_COUNT);
   assign wr_compare = mtc0_en && (bus.cp0_idx == CP0_COMPARE);

   cp0_timer u_timer (
      .clk        (clk),
      .resetn     (resetn),
      .count_we   (wr_count),
      .compare_we (wr_compare),
      .wdata      (bus.cp0_data2w),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         status_im     <= 8'd0;
         status_exl_r  <= 1'b0;
         status_ie     <= 1'b0;
         cause_bd      <= 1'b0;
         cause_ip_hw   <= 6'd0;
         cause_ip_sw   <= 2'd0;
         cause_exccode <= 5'd0;
         epc           <= 32'd0;
         badvaddr      <= 32'd0;
      end else begin
         cause_ip_hw <= {bus.ext_int[5] | ti, bus.ext_int[4:0]};
         if (exc_valid) begin
            cause_exccode <= bus.exc_code[4:0];
            status_exl_r  <= 1'b1;
            // A nested exception keeps the original return point.
            if (!status_exl_r) begin
               epc      <= bus.exc_in_delay_slot ? bus.exc_pc - 32'd4 : bus.exc_pc;
               cause_bd <= bus.exc_in_delay_slot;
            end
            if ((bus.exc_code[4:0] == EXC_ADEL) || (bus.exc_code[4:0] == EXC_ADES))
               badvaddr <= bus.exc_badvaddr;
         end else if (bus.eret) begin
            status_exl_r <= 1'b0;
         end else if (bus.cp0_write) begin
            case (bus.cp0_idx)
               CP0_STATUS: begin
                  status_im    <= bus.cp0_data2w[15:8];
                  status_exl_r <= bus.cp0_data2w[1];
                  status_ie    <= bus.cp0_data2w[0];
               end
               CP0_CAUSE: cause_ip_sw <= bus.cp0_data2w[9:8];
               CP0_EPC:   epc         <= bus.cp0_data2w;
               default: ;
            endcase
         end
      end
   end

   assign status_val = pack_status(status_im, status_exl_r, status_ie);
   assign cause_val  = pack_cause(cause_bd, ti, cause_ip_hw, cause_ip_sw, cause_exccode);

   always_comb begin
      bus.cp0_val = 32'd0;
      case (bus.cp0_idx)
         CP0_BADVADDR: bus.cp0_val = badvaddr;
         CP0_COUNT:    bus.cp0_val = count;
         CP0_COMPARE:  bus.cp0_val = compare;
         CP0_STATUS:   bus.cp0_val = status_val;
         CP0_CAUSE:    bus.cp0_val = cause_val;
         CP0_EPC:      bus.cp0_val = epc;
         default:      bus.cp0_val = 32'd0;
      endcase
   end

   assign bus.d_epc      = epc;
   assign bus.exc_target = EXC_VECTOR;
   assign bus.status_exl = status_exl_r;
   assign bus.int_req    = status_ie & ~status_exl_r &
                           (|({cause_ip_hw, cause_ip_sw} & status_im));

endmodule

// File: tb/tb_cp0_regs.sv
// Directed bench for cp0_regs: reset, timer, exceptions, ERET, priority and interrupt request.
module tb_cp0_regs;
   import cp0_regs_pkg::*;

   logic clk;
   logic resetn;
   int   n_cmp;
   int   n_err;
   logic [31:0] v;
   logic        found;

   cp0_regs_if bus ();

   cp0_regs #(.EXC_VECTOR(32'hBFC0_0380)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [4:0] idx, output logic [31:0] val);
      bus.cp0_idx = idx;
      #1;
      val = bus.cp0_val;
   endtask

   task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
      logic [31:0] val;
      rd(idx, val);
      chk(tag, val, exp);
   endtask

   task automatic mtc0(input logic [4:0] idx, input logic [31:0] data);
      bus.cp0_idx    = idx;
      bus.cp0_data2w = data;
      bus.cp0_write  = 1'b1;
      step();
      bus.cp0_write  = 1'b0;
   endtask

   task automatic take_exc(input logic [5:0] code, input logic [31:0] pc, input logic ds,
                           input logic [31:0] bad);
      bus.exc_code          = code;
      bus.exc_pc            = pc;
      bus.exc_in_delay_slot = ds;
      bus.exc_badvaddr      = bad;
      step();
      bus.exc_code          = 6'd0;
      bus.exc_in_delay_slot = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      resetn = 1'b0;
      bus.cp0_idx = 5'd0;
      bus.cp0_write = 1'b0;
      bus.cp0_data2w = 32'd0;
      bus.exc_code = 6'd0;
      bus.exc_pc = 32'd0;
      bus.exc_in_delay_slot = 1'b0;
      bus.exc_badvaddr = 32'd0;
      bus.eret = 1'b0;
      bus.ext_int = 6'd0;
      repeat (3) step();

      chk_reg("rst_status", CP0_STATUS, 32'h0040_0000);
      chk_reg("rst_cause", CP0_CAUSE, 32'h0);
      chk_reg("rst_epc", CP0_EPC, 32'h0);
      chk_reg("rst_count", CP0_COUNT, 32'h0);
      chk("rst_int_req", {31'd0, bus.int_req}, 32'd0);
      chk("rst_exl", {31'd0, bus.status_exl}, 32'd0);
      chk("exc_target", bus.exc_target, 32'hBFC0_0380);
      resetn = 1'b1;

      repeat (10) step();
      chk_reg("idle_count5", CP0_COUNT, 32'd5);
      chk_reg("idle_status", CP0_STATUS, 32'h0040_0000);
      chk("idle_int_req", {31'd0, bus.int_req}, 32'd0);
      chk_reg("unimpl_idx0", 5'd0, 32'd0);
      chk_reg("unimpl_idx15", 5'd15, 32'd0);

      // RI in a delay slot, then a nested Sys exception
      take_exc(6'b101010, 32'h8000_1004, 1'b1, 32'd0);
      chk_reg("exc1_epc", CP0_EPC, 32'h8000_1000);
      chk_reg("exc1_cause", CP0_CAUSE, 32'h8000_0028);
      chk_reg("exc1_status", CP0_STATUS, 32'h0040_0002);
      chk("exc1_exl", {31'd0, bus.status_exl}, 32'd1);
      chk("exc1_d_epc", bus.d_epc, 32'h8000_1000);
      take_exc(6'b101000, 32'h8000_2000, 1'b0, 32'd0);
      chk_reg("exc2_epc_kept", CP0_EPC, 32'h8000_1000);
      chk_reg("exc2_cause", CP0_CAUSE, 32'h8000_0020);

      bus.eret = 1'b1;
      step();
      bus.eret = 1'b0;
      chk("eret_exl", {31'd0, bus.status_exl}, 32'd0);
      chk_reg("eret_status", CP0_STATUS, 32'h0040_0000);

      // Timer interrupt through IM[15]
      mtc0(CP0_COMPARE, 32'd8);
      mtc0(CP0_COUNT, 32'd0);
      mtc0(CP0_STATUS, 32'h0000_8001);
      chk_reg("tmr_status", CP0_STATUS, 32'h0040_8001);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         rd(CP0_COUNT, v);
         if (v == 32'd8) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk("tmr_count8_reached", {31'd0, found}, 32'd1);
      chk_reg("tmr_cause_ti", CP0_CAUSE, 32'hC000_0020);
      step();
      chk_reg("tmr_count_still8", CP0_COUNT, 32'd8);
      chk_reg("tmr_cause_ip15", CP0_CAUSE, 32'hC000_8020);
      chk("tmr_int_req", {31'd0, bus.int_req}, 32'd1);
      mtc0(CP0_COMPARE, 32'h0000_0100);
      chk_reg("tmr_ti_clr", CP0_CAUSE, 32'h8000_8020);
      step();
      chk_reg("tmr_ip_clr", CP0_CAUSE, 32'h8000_0020);
      chk("tmr_int_req_clr", {31'd0, bus.int_req}, 32'd0);

      // Exception, ERET and MTC0 Status in the same cycle
      bus.eret       = 1'b1;
      bus.cp0_write  = 1'b1;
      bus.cp0_idx    = CP0_STATUS;
      bus.cp0_data2w = 32'h0000_FF00;
      take_exc(6'b100000, 32'h8000_3000, 1'b0, 32'd0);
      bus.eret      = 1'b0;
      bus.cp0_write = 1'b0;
      chk_reg("prio_status", CP0_STATUS, 32'h0040_8003);
      chk_reg("prio_epc", CP0_EPC, 32'h8000_3000);
      chk_reg("prio_cause", CP0_CAUSE, 32'h0000_0000);
      chk("prio_int_req", {31'd0, bus.int_req}, 32'd0);

      // BadVAddr capture only for address errors
      take_exc(6'b100100, 32'h8000_4000, 1'b0, 32'h0000_0003);
      chk_reg("adel_badvaddr", CP0_BADVADDR, 32'h0000_0003);
      chk_reg("adel_cause", CP0_CAUSE, 32'h0000_0010);
      chk_reg("adel_epc_kept", CP0_EPC, 32'h8000_3000);
      take_exc(6'b101000, 32'h8000_5000, 1'b0, 32'h0000_DEAD);
      chk_reg("sys_badvaddr_kept", CP0_BADVADDR, 32'h0000_0003);
      take_exc(6'b100101, 32'h8000_6000, 1'b0, 32'h0000_0044);
      chk_reg("ades_badvaddr", CP0_BADVADDR, 32'h0000_0044);
      mtc0(CP0_BADVADDR, 32'h0000_FFFF);
      chk_reg("badvaddr_ro", CP0_BADVADDR, 32'h0000_0044);

      bus.eret = 1'b1;
      step();
      bus.eret = 1'b0;
      chk_reg("eret2_status", CP0_STATUS, 32'h0040_8001);

      // External interrupt line 0 through IM[10]
      mtc0(CP0_STATUS, 32'h0000_0401);
      chk_reg("ext_status", CP0_STATUS, 32'h0040_0401);
      chk("ext_int_req_idle", {31'd0, bus.int_req}, 32'd0);
      bus.ext_int = 6'b000001;
      step();
      if (bus.int_req !== 1'b1) step();
      chk("ext_int_req", {31'd0, bus.int_req}, 32'd1);
      chk_reg("ext_cause", CP0_CAUSE, 32'h0000_0414);
      mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
      chk_reg("cause_sw_ip", CP0_CAUSE, 32'h0000_0714);
      bus.ext_int = 6'd0;
      step();
      chk_reg("ext_cause_clr", CP0_CAUSE, 32'h0000_0314);
      chk("ext_int_req_clr", {31'd0, bus.int_req}, 32'd0);

      // Count wraps to zero; a zero match must not raise TI
      mtc0(CP0_COMPARE, 32'd0);
      mtc0(CP0_COUNT, 32'hFFFF_FFFF);
      chk_reg("wrap_loaded", CP0_COUNT, 32'hFFFF_FFFF);
      step();
      chk_reg("wrap_hold", CP0_COUNT, 32'hFFFF_FFFF);
      step();
      chk_reg("wrap_zero", CP0_COUNT, 32'd0);
      chk_reg("wrap_no_ti", CP0_CAUSE, 32'h0000_0314);

      // Reset overrides a same-cycle exception
      resetn = 1'b0;
      take_exc(6'b101010, 32'h8000_7004, 1'b1, 32'd0);
      resetn = 1'b1;
      chk_reg("rst2_status", CP0_STATUS, 32'h0040_0000);
      chk_reg("rst2_cause", CP0_CAUSE, 32'h0);
      chk_reg("rst2_epc", CP0_EPC, 32'h0);
      chk_reg("rst2_badvaddr", CP0_BADVADDR, 32'h0);
      chk_reg("rst2_count", CP0_COUNT, 32'h0);
      chk_reg("rst2_compare", CP0_COMPARE, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
